// File: rtl/scc_pkg.sv
// rtl/scc_pkg.sv - shared FSM state and owner encodings for mem_arbiter
package scc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_EX = 1'b1
    } owner_e;

    // Latency counter width; covers MEM_LAT up to 15
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/execute request ports and single-port memory bus
interface mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_rvalid;

    logic        ex_req;
    logic        ex_we;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [31:0] ex_rdata;
    logic        ex_rvalid;

    logic        stall;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, ex_req, ex_we, ex_addr, ex_wdata, mem_rdata,
        output if_rdata, if_rvalid, ex_rdata, ex_rvalid, stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // Pipeline and memory side
    modport master (
        output if_req, if_addr, ex_req, ex_we, ex_addr, ex_wdata, mem_rdata,
        input  if_rdata, if_rvalid, ex_rdata, ex_rvalid, stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - requester select, fixed ex priority or round robin (MEM_ARB_RR_EN)
module mem_arb_pick
    import scc_pkg::*;
(
    input  logic   if_req,
    input  logic   ex_req,
    input  owner_e last_owner,
    output logic   grant_ex
);

`ifdef MEM_ARB_RR_EN
    // On a tie, hand the port to whoever did not own the previous transaction
    always_comb begin
        grant_ex = ex_req && (!if_req || (last_owner == OWN_IF));
    end
`else
    // Execute stage always wins a tie; last_owner is not needed here
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        grant_ex = ex_req;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/execute arbiter for one memory port, round robin under MEM_ARB_RR_EN
module mem_arbiter
    import scc_pkg::*;
#(
    parameter int MEM_LAT = 2
)
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    owner_e            last_owner;
    logic              grant;
    logic              grant_ex;

    // A grant never happens while reset is held
    assign grant = (state_q == IDLE) && !rst && (bus.if_req || bus.ex_req);

    mem_arb_pick u_pick (
        .if_req     (bus.if_req),
        .ex_req     (bus.ex_req),
        .last_owner (last_owner),
        .grant_ex   (grant_ex)
    );

`ifdef MEM_ARB_RR_EN
    owner_e last_owner_q, last_owner_d;

    assign last_owner_d = grant ? (grant_ex ? OWN_EX : OWN_IF) : last_owner_q;
    assign last_owner   = last_owner_q;

    // Track the owner of the most recent grant for tie breaking
    always_ff @(posedge clk) begin
        if (rst) last_owner_q <= OWN_IF;
        else     last_owner_q <= last_owner_d;
    end
`else
    assign last_owner = OWN_IF;
`endif

    // FSM state and latched transaction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state, grant latch and all bus outputs; outputs are quiet during reset
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.ex_rvalid = 1'b0;
        bus.ex_rdata  = '0;
        bus.stall     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d       = grant_ex ? OWN_EX : OWN_IF;
                    addr_d        = grant_ex ? bus.ex_addr : bus.if_addr;
                    we_d          = grant_ex && bus.ex_we;
                    wdata_d       = grant_ex ? bus.ex_wdata : 32'h0;
                    cnt_d         = LAT_M1;
                    state_d       = (MEM_LAT == 1) ? DONE : WAIT;
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = we_d;
                    bus.mem_addr  = addr_d;
                    bus.mem_wdata = wdata_d;
                    bus.stall     = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) state_d = DONE;
                if (!rst) begin
                    bus.mem_we    = we_q;
                    bus.mem_addr  = addr_q;
                    bus.mem_wdata = wdata_q;
                    bus.stall     = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!rst) begin
                    bus.mem_we    = we_q;
                    bus.mem_addr  = addr_q;
                    bus.mem_wdata = wdata_q;
                    if (owner_q == OWN_EX) begin
                        bus.ex_rvalid = 1'b1;
                        bus.ex_rdata  = we_q ? 32'h0 : bus.mem_rdata;
                        bus.stall     = bus.if_req;
                    end else begin
                        bus.if_rvalid = 1'b1;
                        bus.if_rdata  = bus.mem_rdata;
                        bus.stall     = bus.ex_req;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
